load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 64, number of 32-bit words in the attached data memory; valid byte addresses are 0 .. 4*MEM_WORDS-1.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  out  1  valid with resp_valid; request was misaligned, out of range or illegal size.
REQ-014 mem_posicao  out  32  word index to data memory, {zeros, addr[7:2]} for MEM_WORDS=64.
REQ-015 mem_dados  out  32  full word to be written.
REQ-016 mem_write  out  1  data-memory write enable; memory writes on the rising edge where it is high.
REQ-017 mem_read  out  1  data-memory read strobe.
REQ-018 mem_saida  in  32  combinational read word from data memory at mem_posicao.

Function
REQ-019 FSM states: IDLE, ACCESS, WRITE, RESP; encoding is free.
REQ-020 req_ready is 1 only in IDLE; the request is accepted on a rising edge with req_valid && req_ready, latching write, size, unsigned, addr and wdata.
REQ-021 Error check at acceptance: size 11, halfword with addr[0]=1, word with addr[1:0]!=00, or addr >= 4*MEM_WORDS, goes IDLE->RESP with resp_error=1; memory is not accessed.
REQ-022 Legal request: IDLE->ACCESS; in ACCESS mem_read=1, mem_posicao=latched word index, mem_saida is captured into an internal word register at the exit edge.
REQ-023 ACCESS->RESP for loads; ACCESS->WRITE for stores.
REQ-024 WRITE: mem_write=1 for exactly one cycle, mem_dados = captured word with the addressed lanes replaced (little-endian: byte lane n = bits 8n+7:8n, n=addr[1:0]; halfword lanes addr[1]*2, +1; word replaces all); unaddressed lanes are unchanged; then WRITE->RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then RESP->IDLE; resp_rdata/resp_error held stable that cycle and 0 otherwise.
REQ-026 Load data: selected lane shifted to bit 0, extended to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-027 Latency from accept edge to resp_valid high: error 1 cycle, load 2 cycles, store 3 cycles; next request accepted earliest on the cycle after RESP.
REQ-028 mem_write and mem_read are 0 in all states other than those stated; mem_posicao holds the last latched index.
REQ-029 req_valid while req_ready=0 is ignored and never queued.

Reset
REQ-030 rst asserted: FSM to IDLE immediately; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_read=0, mem_posicao=0, mem_dados=0, internal registers 0.
REQ-031 rst asserted during WRITE drops mem_write before the next edge; no memory write occurs and no response is produced for the aborted request.

Verification
REQ-032 Word store addr 0x10, wdata 0xDEADBEEF, then word load 0x10 -> mem_write one cycle with mem_posicao=4, resp 3 cycles after store accept; load resp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-033 Word 0x11223344 at 0x20; byte store 0xAA at 0x22 -> memory word 0x11AA3344; signed byte load 0x22 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-034 Halfword store 0x8001 at 0x26 over 0x00000000 -> word 0x80010000; signed halfword load 0x26 -> 0xFFFF8001.
REQ-035 Word load 0x13, halfword load 0x05, word load 0x100, size 11 -> each resp_error=1, resp_rdata=0, 1-cycle latency, mem_read/mem_write never asserted.
REQ-036 rst pulsed during WRITE of byte store 0x55 to 0x30 (word 0xCAFEF00D) -> mem_write falls with rst, word stays 0xCAFEF00D, no resp_valid, req_ready=1.
REQ-037 req_valid held high continuously with alternating requests -> each accepted only in IDLE, responses one per request, in order.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// Load/store unit between a simple request port and a single-port data memory
// with a combinational read. Handles byte/halfword/word accesses with
// little-endian lane selection, sign/zero extension on loads and
// read-modify-write merging on sub-word stores.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while the unit is idle. A request offered while the
// unit is busy is ignored, not queued. Every accepted request produces exactly
// one resp_valid pulse, in order, unless reset aborts it.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_posicao,
    output logic [31:0] mem_dados,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_saida,
    output logic [1:0]  dbg_state
);

    localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    logic               write_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic [1:0]         lane_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        word_q;

    logic               req_bad;
    logic [31:0]        store_word;
    logic [31:0]        load_val;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;

    // Classify an incoming request as illegal: bad size, misaligned or out of range.
    always_comb begin
        req_bad = (req_addr >= ADDR_LIMIT);
        case (req_size)
            2'b00:   req_bad = req_bad;
            2'b01:   req_bad = req_bad | req_addr[0];
            2'b10:   req_bad = req_bad | (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Merge the store data into the captured memory word on the addressed lanes.
    always_comb begin
        store_word = word_q;
        case (size_q)
            2'b00:   store_word[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   store_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    // Pick the addressed lane of the captured word and extend it to 32 bits.
    always_comb begin
        load_byte = word_q[{lane_q, 3'b000} +: 8];
        load_half = word_q[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_val = unsigned_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_val = word_q;
        endcase
    end

    // Request sequencing: accept, read memory, optionally write back, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            lane_q     <= 2'b00;
            idx_q      <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            idx_q    <= req_addr[IDX_W+1:2];
                            mem_read <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    mem_read <= 1'b0;
                    word_q   <= mem_saida;
                    if (write_q) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign dbg_state   = state;
    assign mem_posicao = {{(32-IDX_W){1'b0}}, idx_q};
    assign mem_dados   = (state == WRITE) ? store_word : 32'd0;
    assign resp_rdata  = (resp_valid && !resp_error && !write_q) ? load_val : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Bench for load_store_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a byte-addressed memory model.
module tb_load_store_unit;

    localparam int MW = 64;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_posicao;
    logic [31:0] mem_dados;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_saida;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_posicao  (mem_posicao),
        .mem_dados    (mem_dados),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_saida    (mem_saida),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Attached data memory (environment, not the reference)
    logic [31:0] env_mem [0:MW-1];
    assign mem_saida = env_mem[mem_posicao % MW];
    always @(posedge clk) begin
        if (mem_write) env_mem[mem_posicao % MW] <= mem_dados;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Reference model: byte-addressed memory plus transaction timeline
    logic [7:0]  ref_b [0:4*MW-1];
    logic [32:0] exp_q [$];
    bit          m_busy = 1'b0;
    int          m_t, m_lat, m_nb, m_addr;
    bit          m_write, m_err;
    logic [31:0] m_idx, m_new, m_wdata, m_a, m_rd, m_w;

    function automatic logic [31:0] ref_word(input int k);
        return {ref_b[4*k+3], ref_b[4*k+2], ref_b[4*k+1], ref_b[4*k]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (m_write && !m_err && m_t == 2)
                for (int i = 0; i < m_nb; i++) ref_b[m_addr+i] = m_wdata[8*i +: 8];
            m_t++;
            if (m_t > m_lat) m_busy = 1'b0;
        end else if (req_valid) begin
            m_a     = req_addr;
            m_err   = (req_size == 2'd3) || (req_size == 2'd1 && m_a[0]) ||
                      (req_size == 2'd2 && m_a[1:0] != 2'b00) || (m_a >= 32'(4*MW));
            m_write = req_write;
            m_wdata = req_wdata;
            m_nb    = 1 << req_size;
            m_lat   = m_err ? 1 : (req_write ? 3 : 2);
            m_t     = 1;
            m_busy  = 1'b1;
            m_rd    = 32'd0;
            if (!m_err) begin
                m_addr = int'(m_a);
                m_idx  = m_a / 4;
                if (req_write) begin
                    m_w = ref_word(m_addr / 4);
                    for (int i = 0; i < m_nb; i++) m_w[8*((m_addr+i)%4) +: 8] = req_wdata[8*i +: 8];
                    m_new = m_w;
                end else begin
                    for (int i = 0; i < m_nb; i++) m_rd[8*i +: 8] = ref_b[m_addr+i];
                    if (!req_unsigned && m_nb < 4 && m_rd[8*m_nb-1]) m_rd = m_rd | (32'hFFFF_FFFF << (8*m_nb));
                end
            end
            exp_q.push_back({m_err, m_rd});
        end
    end

    // Scoreboard: compare DUT outputs with the model on every cycle out of reset
    logic [32:0] e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", req_ready, !m_busy);
            chk("mem_read", mem_read, m_busy && !m_err && m_t == 1);
            chk("mem_write", mem_write, m_busy && m_write && !m_err && m_t == 2);
            chk("resp_valid", resp_valid, m_busy && m_t == m_lat);
            if (m_busy && !m_err && (m_t == 1 || (m_t == 2 && m_write)))
                chk("mem_posicao", mem_posicao, m_idx);
            if (m_busy && m_write && !m_err && m_t == 2)
                chk("mem_dados", mem_dados, m_new);
            if (m_busy && m_t == m_lat) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_error", resp_error, e[32]);
                    chk("resp_rdata", resp_rdata, e[31:0]);
                end else begin
                    n_checks++;
                    $display("FAIL resp_order: got response, expected none queued");
                end
            end else begin
                chk("quiet_rdata", resp_rdata, 32'd0);
                chk("quiet_error", resp_error, 32'd0);
            end
        end
    end

    // Driver tasks
    task automatic send(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", req_ready, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic txn(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        send(w, sz, u, a, wd);
        lat = 1;
        while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
        rd = resp_rdata;
        er = resp_error;
    endtask

    task automatic rand_fields();
        logic [31:0] a;
        int r;
        req_write    = 1'($urandom_range(0, 1));
        req_size     = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        req_unsigned = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else if (r < 3)  a = 32'($urandom_range(240, 271));
        else             a = 32'($urandom_range(0, 255));
        if (req_size != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << req_size) - 32'd1);
        req_addr  = a;
        req_wdata = $urandom;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] err_addr [4] = '{32'h13, 32'h05, 32'h100, 32'h00};
    logic [1:0]  err_size [4] = '{2'd2, 2'd1, 2'd2, 2'd3};

    initial begin
        for (int i = 0; i < MW; i++) env_mem[i] = 32'd0;
        for (int i = 0; i < 4*MW; i++) ref_b[i] = 8'd0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        #3;
        chk("rst_ready", req_ready, 32'd1);
        chk("rst_resp_valid", resp_valid, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_error", resp_error, 32'd0);
        chk("rst_mem_write", mem_write, 32'd0);
        chk("rst_mem_read", mem_read, 32'd0);
        chk("rst_posicao", mem_posicao, 32'd0);
        chk("rst_dados", mem_dados, 32'd0);
        #19 rst = 1'b0;

        // Word store then word load
        txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        chk("st_word_lat", lat, 32'd3);
        chk("st_word_err", er, 32'd0);
        chk("st_word_mem", env_mem[4], 32'hDEAD_BEEF);
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
        chk("ld_word_lat", lat, 32'd2);
        chk("ld_word_data", rd, 32'hDEAD_BEEF);

        // Byte store into an existing word, signed and unsigned byte loads
        txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, rd, er, lat);
        txn(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, rd, er, lat);
        chk("st_byte_mem", env_mem[8], 32'h11AA_3344);
        txn(1'b0, 2'd0, 1'b0, 32'h22, 32'd0, rd, er, lat);
        chk("ld_byte_s", rd, 32'hFFFF_FFAA);
        txn(1'b0, 2'd0, 1'b1, 32'h22, 32'd0, rd, er, lat);
        chk("ld_byte_u", rd, 32'h0000_00AA);

        // Upper halfword store and signed halfword load
        txn(1'b1, 2'd2, 1'b0, 32'h24, 32'h0000_0000, rd, er, lat);
        txn(1'b1, 2'd1, 1'b0, 32'h26, 32'h0000_8001, rd, er, lat);
        chk("st_half_mem", env_mem[9], 32'h8001_0000);
        txn(1'b0, 2'd1, 1'b0, 32'h26, 32'd0, rd, er, lat);
        chk("ld_half_s", rd, 32'hFFFF_8001);

        // Illegal requests: misaligned, out of range, bad size
        for (int k = 0; k < 4; k++) begin
            txn(1'b0, err_size[k], 1'b0, err_addr[k], 32'd0, rd, er, lat);
            chk("err_flag", er, 32'd1);
            chk("err_rdata", rd, 32'd0);
            chk("err_lat", lat, 32'd1);
        end

        // Reset during the write cycle of a byte store
        txn(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D, rd, er, lat);
        send(1'b1, 2'd0, 1'b0, 32'h30, 32'h0000_0055);
        @(negedge clk);
        chk("abort_mw_before", mem_write, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_mw_after", mem_write, 32'd0);
        chk("abort_ready", req_ready, 32'd1);
        chk("abort_resp", resp_valid, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_mem", env_mem[12], 32'hCAFE_F00D);

        // req_valid held high with a new request offered every cycle
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid = 1'b1;
            rand_fields();
        end
        // Random traffic with gaps
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 7) != 0);
            rand_fields();
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);

        chk("queue_drained", exp_q.size(), 32'd0);
        for (int w = 0; w < MW; w++) chk("final_mem", env_mem[w], ref_word(w));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
